pipe_adder: RTL and testbench
=============================

PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result width in bits.
REQ-002 SHALL have parameter STAGES, default 2, meaning number of pipeline stages; WIDTH SHALL be an integer multiple of STAGES; SLICE = WIDTH/STAGES.
REQ-003 SHALL have port clk  input  1  rising-edge clock; one clock domain.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-005 SHALL have port in_valid  input  1  operands valid this cycle.
REQ-006 SHALL have port x  input  WIDTH  operand A, unsigned/two's complement.
REQ-007 SHALL have port y  input  WIDTH  operand B.
REQ-008 SHALL have port sub  input  1  0 = x+y, 1 = x-y; sampled with in_valid.
REQ-009 SHALL have port out_valid  output  1  result valid, one-cycle pulse per accepted operation.
REQ-010 SHALL have port sum  output  WIDTH  result bits.
REQ-011 SHALL have port carry  output  1  carry out of MSB; for sub, 1 = no borrow.
REQ-012 SHALL have port ovf  output  1  two's-complement signed overflow.

Function
REQ-013 SHALL accept one operation every cycle in_valid=1; no backpressure, no stall input.
REQ-014 Stage k (0..STAGES-1) SHALL compute bits [k*SLICE +: SLICE] using carry registered from stage k-1; stage 0 carry-in = sub.
REQ-015 For sub=1, SHALL add bitwise-inverted y with carry-in 1 (x + ~y + 1).
REQ-016 Upper operand slices and the sub bit SHALL be delay-registered (skewed) so each slice meets its carry in the correct cycle; lower result slices delay-registered so all bits emerge together.
REQ-017 Latency SHALL be exactly STAGES cycles: operands sampled at edge N appear on sum/carry/ovf with out_valid=1 after edge N+STAGES-1's successor, i.e. visible in the cycle following edge N+STAGES-1.
REQ-018 Results SHALL emerge in acceptance order, one per accepted input, with bubbles preserved (in_valid=0 cycles yield out_valid=0 cycles at same spacing).
REQ-019 ovf SHALL equal carry into MSB XOR carry out of MSB of the effective addition.
REQ-020 When out_valid=0, sum/carry/ovf SHALL hold the last valid result (not update from bubbles).
REQ-021 x, y, sub SHALL be don't-care when in_valid=0 and SHALL NOT affect any output.
REQ-022 STAGES=1 SHALL degenerate to a single registered adder with 1-cycle latency; STAGES=WIDTH SHALL be a bit-serial-skewed pipeline.
REQ-023 Valid tracking SHALL be a STAGES-deep shift register of in_valid.

Reset
REQ-024 On rst=1 at a clock edge, out_valid, sum, carry, ovf and all internal pipeline/valid registers SHALL become 0 by the next cycle.
REQ-025 Reset mid-operation SHALL discard all in-flight operations; none SHALL appear with out_valid=1 afterwards.
REQ-026 An operation presented with in_valid=1 in the same cycle rst=1 SHALL be discarded.
REQ-027 The first operation accepted in the cycle after rst deasserts SHALL emerge with normal STAGES latency.

Verification (WIDTH=8, STAGES=2 unless noted)
REQ-028 x=0xFF, y=0x01, sub=0 -> 2 cycles later out_valid=1, sum=0x00, carry=1, ovf=0.
REQ-029 x=0x7F, y=0x01, sub=0 -> sum=0x80, carry=0, ovf=1; x=0x05, y=0x07, sub=1 -> sum=0xFE, carry=0, ovf=0; x=0x80, y=0x01, sub=1 -> sum=0x7F, carry=1, ovf=1.
REQ-030 10 back-to-back random pairs (file-driven, golden {carry,sum} 9-bit hex) -> 10 consecutive out_valid pulses, all matching golden in order, zero mismatches.
REQ-031 Pattern in_valid=1,0,0,1 -> out_valid=1,0,0,1 offset by 2 cycles; sum holds first result during the bubbles.
REQ-032 Two operations in flight, assert rst 1 cycle -> out_valid stays 0 thereafter until a new operation is accepted; all outputs read 0 after reset.
REQ-033 Repeat REQ-030 with WIDTH=16, STAGES=4 and WIDTH=8, STAGES=1 -> latency 4 and 1 respectively, all results match golden.

Source files
------------

// File: rtl/pipe_adder.sv
// pipe_adder: carry-skewed pipelined adder/subtractor, one SLICE-wide slice per stage
module pipe_adder #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sub,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf
);
  localparam int SLICE = WIDTH / STAGES;
  logic [WIDTH-1:0] sx [STAGES];
  logic [WIDTH-1:0] sy [STAGES];
  logic             sc [STAGES];
  logic             sv [STAGES];
  logic [SLICE:0]   s [STAGES];
  logic [WIDTH-1:0] xr_d [STAGES];
  logic [WIDTH-1:0] y_d [STAGES];
  logic             c_d [STAGES];
  logic             ovf_d;
  logic [WIDTH-1:0] xr_q [STAGES];
  logic [WIDTH-1:0] y_q [STAGES];
  logic             c_q [STAGES];
  logic             v_q [STAGES];
  logic             ovf_q;
  // each stage adds the low slice of its operands; x shifts down while result slices shift in at the top
  always_comb begin
    sx[0] = x;
    sy[0] = sub ? ~y : y;
    sc[0] = sub;
    sv[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      sx[k] = xr_q[k-1];
      sy[k] = y_q[k-1];
      sc[k] = c_q[k-1];
      sv[k] = v_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      s[k]    = {1'b0, sx[k][SLICE-1:0]} + {1'b0, sy[k][SLICE-1:0]} + {{SLICE{1'b0}}, sc[k]};
      xr_d[k] = (sx[k] >> SLICE) | (WIDTH'(s[k][SLICE-1:0]) << (WIDTH - SLICE));
      y_d[k]  = sy[k] >> SLICE;
      c_d[k]  = s[k][SLICE];
    end
    ovf_d = sx[STAGES-1][SLICE-1] ^ sy[STAGES-1][SLICE-1] ^ s[STAGES-1][SLICE-1] ^ s[STAGES-1][SLICE];
  end
  // inner stages advance every cycle; the output stage only loads on a valid result so bubbles hold it
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        xr_q[k] <= '0;
        y_q[k]  <= '0;
        c_q[k]  <= 1'b0;
        v_q[k]  <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) v_q[k] <= sv[k];
      for (int k = 0; k < STAGES - 1; k++) begin
        xr_q[k] <= xr_d[k];
        y_q[k]  <= y_d[k];
        c_q[k]  <= c_d[k];
      end
      if (sv[STAGES-1]) begin
        xr_q[STAGES-1] <= xr_d[STAGES-1];
        c_q[STAGES-1]  <= c_d[STAGES-1];
        ovf_q          <= ovf_d;
      end
    end
  end
  assign out_valid = v_q[STAGES-1];
  assign sum       = xr_q[STAGES-1];
  assign carry     = c_q[STAGES-1];
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: scoreboard bench for three pipe_adder configurations driven in lockstep
module tb_pipe_adder;
  typedef struct {
    int          due;
    logic [15:0] s;
    logic        c;
    logic        o;
  } exp_t;
  localparam int WD [3] = '{8, 16, 8};
  localparam int LT [3] = '{2, 4, 1};
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        sub = 1'b0;
  logic [15:0] x = '0;
  logic [15:0] y = '0;
  logic        ov [3];
  logic        oc [3];
  logic        oo [3];
  logic [15:0] os [3];
  logic [7:0]  s_a, s_c;
  logic [15:0] s_b;
  exp_t        q [3][$];
  exp_t        last [3];
  int          cyc = 0;
  int          checks = 0;
  int          errs = 0;

  always #5 clk = ~clk;

  pipe_adder #(.WIDTH(8), .STAGES(2)) u_a (.clk(clk), .rst(rst), .in_valid(in_valid), .x(x[7:0]), .y(y[7:0]),
    .sub(sub), .out_valid(ov[0]), .sum(s_a), .carry(oc[0]), .ovf(oo[0]));
  pipe_adder #(.WIDTH(16), .STAGES(4)) u_b (.clk(clk), .rst(rst), .in_valid(in_valid), .x(x), .y(y),
    .sub(sub), .out_valid(ov[1]), .sum(s_b), .carry(oc[1]), .ovf(oo[1]));
  pipe_adder #(.WIDTH(8), .STAGES(1)) u_c (.clk(clk), .rst(rst), .in_valid(in_valid), .x(x[7:0]), .y(y[7:0]),
    .sub(sub), .out_valid(ov[2]), .sum(s_c), .carry(oc[2]), .ovf(oo[2]));
  assign os[0] = {8'h00, s_a};
  assign os[1] = s_b;
  assign os[2] = {8'h00, s_c};

  function automatic exp_t model(int w, int lat, logic [15:0] a, logic [15:0] b, logic sb);
    exp_t        e;
    logic [16:0] m, t;
    logic [15:0] ye;
    m     = (17'd1 << w) - 17'd1;
    ye    = sb ? ~b : b;
    t     = ({1'b0, a} & m) + ({1'b0, ye} & m) + 17'(sb);
    e.due = cyc + lat;
    e.s   = t[15:0] & m[15:0];
    e.c   = t[w];
    e.o   = (a[w-1] == ye[w-1]) && (t[w-1] != a[w-1]);
    return e;
  endfunction

  task automatic op(input logic [15:0] a, input logic [15:0] b, input logic sb);
    in_valid = 1'b1;
    x = a;
    y = b;
    sub = sb;
    for (int i = 0; i < 3; i++) q[i].push_back(model(WD[i], LT[i], a, b, sb));
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) begin
      in_valid = 1'b0;
      x = 16'($urandom);
      y = 16'($urandom);
      sub = 1'($urandom);
      @(negedge clk);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) for (int i = 0; i < 3; i++) begin
      q[i].delete();
      last[i] = '{due: 0, s: 16'h0, c: 1'b0, o: 1'b0};
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      logic exp_v;
      exp_v = q[i].size() > 0 && q[i][0].due == cyc;
      checks++;
      assert (ov[i] === exp_v) else begin
        errs++;
        $error("FAIL valid%0d cyc=%0d observed=%b expected=%b", i, cyc, ov[i], exp_v);
      end
      if (exp_v) last[i] = q[i].pop_front();
      checks++;
      assert ({oc[i], oo[i], os[i]} === {last[i].c, last[i].o, last[i].s}) else begin
        errs++;
        $error("FAIL data%0d cyc=%0d observed c=%b o=%b s=%h expected c=%b o=%b s=%h",
               i, cyc, oc[i], oo[i], os[i], last[i].c, last[i].o, last[i].s);
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      assert ({ov[i], oc[i], oo[i], os[i]} === 19'h0) else begin
        errs++;
        $error("FAIL rst%0d observed=%h expected=0", i, {ov[i], oc[i], oo[i], os[i]});
      end
    end
    rst = 1'b0;
    op(16'h00FF, 16'h0001, 1'b0);
    op(16'h007F, 16'h0001, 1'b0);
    op(16'h0005, 16'h0007, 1'b1);
    op(16'h0080, 16'h0001, 1'b1);
    op(16'h8000, 16'h0001, 1'b1);
    op(16'h7FFF, 16'h0001, 1'b0);
    idle(5);
    op(16'h1234, 16'h0F0F, 1'b0);
    idle(2);
    op(16'hABCD, 16'h5555, 1'b1);
    idle(5);
    for (int j = 0; j < 10; j++) op(16'($urandom), 16'($urandom), 1'($urandom));
    idle(5);
    op(16'h0011, 16'h0022, 1'b0);
    op(16'h0033, 16'h0044, 1'b1);
    rst = 1'b1;
    in_valid = 1'b1;
    x = 16'h00F0;
    y = 16'h000F;
    sub = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      assert ({ov[i], oc[i], oo[i], os[i]} === 19'h0) else begin
        errs++;
        $error("FAIL midrst%0d observed=%h expected=0", i, {ov[i], oc[i], oo[i], os[i]});
      end
    end
    rst = 1'b0;
    idle(6);
    op(16'hFFFF, 16'hFFFF, 1'b0);
    op(16'h0001, 16'h0002, 1'b1);
    idle(6);
    for (int i = 0; i < 3; i++) begin
      checks++;
      assert (q[i].size() === 0) else begin
        errs++;
        $error("FAIL drain%0d observed=%0d expected=0", i, q[i].size());
      end
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
